// File: rtl/bullet_hit_detector.sv
// Per-cannon hit detector: latches the bullet's grid cell, walks the snake
// segment store over a 1-cycle-latency read port, and reports one hit per shot.
module bullet_hit_detector #(
   parameter  int GRID_W     = 40,
   parameter  int GRID_H     = 30,
   parameter  int MAX_LEN    = 64,
   parameter  int CELL_SHIFT = 4,
   localparam int IDX_W      = $clog2(MAX_LEN),
   localparam int GX_W       = $clog2(GRID_W),
   localparam int GY_W       = $clog2(GRID_H)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             game_over,
   input  logic [9:0]       bullet_px,
   input  logic [9:0]       bullet_py,
   input  logic             bullet_active,
   input  logic [IDX_W:0]   snake_len,
   output logic             seg_rd_en,
   output logic [IDX_W-1:0] seg_addr,
   input  logic [GX_W-1:0]  seg_x,
   input  logic [GY_W-1:0]  seg_y,
   output logic             hit_pulse,
   output logic             hit_head,
   output logic [IDX_W-1:0] hit_index,
   output logic             scan_busy
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} state_t;

   state_t           state, state_nxt;
   logic [9:0]       gx_full, gy_full;
   logic [GX_W-1:0]  gx, lat_x;
   logic [GY_W-1:0]  gy, lat_y;
   logic             on_grid, armed, trigger;
   logic [IDX_W:0]   len_q;
   logic [IDX_W-1:0] addr_q, cmp_idx;
   logic             cmp_valid, match, last_addr;

   assign gx_full = bullet_px >> CELL_SHIFT;
   assign gy_full = bullet_py >> CELL_SHIFT;
   assign on_grid = (gx_full < 10'(GRID_W)) && (gy_full < 10'(GRID_H));
   assign gx      = gx_full[GX_W-1:0];
   assign gy      = gy_full[GY_W-1:0];

   assign trigger = bullet_active && !game_over && (snake_len != '0) && on_grid &&
                    (!armed || (gx != lat_x) || (gy != lat_y));

   // Only data returned for a read issued while still scanning is compared.
   assign match     = (state == SCAN || state == DRAIN) && cmp_valid &&
                      (seg_x == lat_x) && (seg_y == lat_y);
   assign last_addr = ({1'b0, addr_q} == (len_q - (IDX_W+1)'(1)));
   assign seg_addr  = addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nxt = state;
      seg_rd_en = 1'b0;
      scan_busy = 1'b0;
      case (state)
         IDLE:  if (trigger) state_nxt = SCAN;
         SCAN: begin
            scan_busy = 1'b1;
            seg_rd_en = !game_over;
            if (match)          state_nxt = HOLD;
            else if (last_addr) state_nxt = DRAIN;
         end
         DRAIN: begin
            scan_busy = 1'b1;
            state_nxt = match ? HOLD : IDLE;
         end
         HOLD:  if (!bullet_active) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (game_over) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_x     <= '1;
         lat_y     <= '1;
         armed     <= 1'b0;
         len_q     <= '0;
         addr_q    <= '0;
         cmp_valid <= 1'b0;
         cmp_idx   <= '0;
         hit_pulse <= 1'b0;
         hit_head  <= 1'b0;
         hit_index <= '0;
      end else begin
         hit_pulse <= match && !game_over;
         if (match && !game_over) begin
            hit_index <= cmp_idx;
            hit_head  <= (cmp_idx == '0);
         end
         cmp_valid <= seg_rd_en;
         cmp_idx   <= addr_q;

         if (state == IDLE && trigger) begin
            lat_x  <= gx;
            lat_y  <= gy;
            armed  <= 1'b1;
            len_q  <= snake_len;
            addr_q <= '0;
         end else if (state == SCAN && !last_addr) begin
            addr_q <= addr_q + IDX_W'(1);
         end

         // A released trigger re-arms the detector for the next shot.
         if ((state == IDLE || state == HOLD) && !bullet_active) armed <= 1'b0;
      end
   end

endmodule

// File: doc/bullet_hit_detector.md
Name: bullet_hit_detector

Overview:
Receiving end of the cannon bullet interface. It samples a cannon's bullet pixel position and active flag, converts the position to grid coordinates, and scans the snake body segment store over a 1-cycle-latency read port. It reports at most one hit per shot, giving the segment index and a head flag. One instance sits per cannon, between that cannon's controller and the game-state logic.

Parameters:
GRID_W, 40, grid width in cells
GRID_H, 30, grid height in cells
MAX_LEN, 64, maximum snake segments; IDX_W = $clog2(MAX_LEN)
CELL_SHIFT, 4, log2 of cell size in pixels (16 px)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
game_over  in  1  aborts any scan and suppresses hits
bullet_px  in  10  bullet X pixel
bullet_py  in  10  bullet Y pixel
bullet_active  in  1  bullet in flight
snake_len  in  IDX_W+1  current segment count (0..MAX_LEN)
seg_rd_en  out  1  segment store read strobe
seg_addr  out  IDX_W  segment index; 0 = head
seg_x  in  $clog2(GRID_W)  segment X, valid 1 cycle after seg_rd_en
seg_y  in  $clog2(GRID_H)  segment Y, valid 1 cycle after seg_rd_en
hit_pulse  out  1  one-cycle hit strobe
hit_head  out  1  qualifies hit_pulse: hit segment was index 0
hit_index  out  IDX_W  index of the hit segment; holds until the next hit
scan_busy  out  1  high in SCAN/DRAIN

Behaviour:
- Reset (async, rst=1): state IDLE; hit_pulse, hit_head, hit_index, seg_rd_en, seg_addr, scan_busy = 0; lat_x/lat_y = all ones; armed = 0. Reset mid-scan abandons the scan with no hit.
- Grid conversion: gx = bullet_px >> CELL_SHIFT, gy = bullet_py >> CELL_SHIFT. If gx >= GRID_W or gy >= GRID_H, the position is off-grid and is never scanned.
- Trigger: in IDLE, the block starts a scan on cycle T when all of the following hold:
  - bullet_active = 1
  - game_over = 0
  - snake_len != 0
  - the position is on-grid
  - armed = 0, or (gx, gy) != (lat_x, lat_y)
- At the T edge: (lat_x, lat_y) <= (gx, gy); armed <= 1; go to SCAN.
- SCAN: seg_rd_en = 1 with seg_addr = 0, 1, 2, … on cycles T+1, T+2, ….
  - Data for address k is compared at T+2+k against (lat_x, lat_y).
  - After issuing address snake_len-1, go to DRAIN (no read) to compare the last datum.
- Hit: on the first match at index k:
  - hit_pulse = 1 for exactly one cycle at T+3+k, with hit_index = k and hit_head = (k == 0).
  - seg_rd_en drops from T+3+k and any in-flight datum is ignored.
  - State goes to HOLD.
- No match: after DRAIN compares the last datum, return to IDLE with no pulse. The latched position blocks a rescan of the same cell.
- HOLD: no scans. Leave to IDLE when bullet_active = 0, which also clears armed. This gives one hit per shot.
- IDLE with bullet_active = 0 clears armed.
- Moves during a scan: a bullet move while in SCAN is ignored. On return to IDLE, the differing position retriggers.
- snake_len changes during a scan: the value latched at T is used.
- game_over = 1: any state goes to IDLE on the next edge; seg_rd_en = 0; no hit_pulse, even if a match compares in that same cycle. No new scans start while game_over is high.
- Scan length is snake_len+1 cycles worst case (2 cycles for a 1-segment snake). This is far shorter than the bullet update period.

Test Plan:
- Head hit: segments (10,12),(9,12),(8,12), snake_len = 3; bullet_px = 160, bullet_py = 200, active at T -> seg_addr 0 at T+1, hit_pulse at T+3, hit_head = 1, hit_index = 0, seg_rd_en low from T+3.
- Body hit with single report: same snake, bullet (130,200) -> gx = 8, hit_pulse at T+5, hit_index = 2, hit_head = 0. Bullet moves to (131,201) while still active -> no further pulse until bullet_active falls and a new shot arrives.
- Miss and no rescan: bullet (320,64) -> addresses 0..2 issued, DRAIN, back to IDLE, no pulse. Same cell held 50 cycles -> no rescan. Move to (336,64) -> new scan starts.
- Off-grid and empty: bullet_px = 645, or snake_len = 0 -> seg_rd_en never asserts, scan_busy stays 0.
- Abort: game_over rises on the cycle the matching datum for index 1 is compared -> no hit_pulse, state IDLE, no scans while game_over = 1.
- Reset mid-scan: rst pulses during SCAN -> all outputs 0 immediately (async). After release, a same-position active bullet triggers a fresh scan because armed is 0.
